// File: rtl/xorshift_rng_bank.sv
// Multi-channel 32-bit xorshift random source. Each channel yields an OUT_W-bit
// uniform word plus a Bernoulli spike bit (word < prob slice). Draws are
// presented on a registered valid/ready port so downstream stages can stall
// without losing or skipping draws. Channels can be reseeded at runtime.
//
// Handshake: out_valid high means rnd_out/spike_out hold a draw that has not
// yet been consumed; the draw is consumed on any cycle where out_valid and
// out_ready are both high, and it is held unchanged while out_valid is high
// and out_ready is low.
module xorshift_rng_bank #(
    parameter int          NUM_CH = 4,
    parameter int          OUT_W  = 8,
    parameter logic [31:0] SEED   = 32'h92D68CA2,
    parameter int          CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NUM_CH*OUT_W-1:0]   prob,
    input  logic                      seed_we,
    input  logic [CH_W-1:0]           seed_ch,
    input  logic [31:0]               seed_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CH*OUT_W-1:0]   rnd_out,
    output logic [NUM_CH-1:0]         spike_out
);

    // One xorshift32 step (13/17/5). Zero maps to zero, so state must never be 0.
    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    // Per-channel reset seed, decorrelated by the golden-ratio constant.
    function automatic logic [31:0] reset_seed(input int idx);
        logic [31:0] s;
        s = SEED ^ (32'(idx) * 32'h9E3779B9);
        return (s == 32'd0) ? SEED : s;
    endfunction

    logic [31:0] state    [NUM_CH];
    logic [31:0] nxt      [NUM_CH];
    logic [NUM_CH-1:0] seed_hit;
    logic [31:0] seed_val;
    logic        adv;
    logic        accept;

    // Advance only when requested, not reseeding, and the output slot is free or being freed.
    assign adv      = en && !seed_we && (!out_valid || out_ready);
    assign accept   = out_valid && out_ready;
    assign seed_val = (seed_data == 32'd0) ? SEED : seed_data;

    // Next state of every channel and which channel (if any) is being reseeded.
    always_comb begin
        seed_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            nxt[i]      = xs(state[i]);
            seed_hit[i] = seed_we && (32'(seed_ch) == 32'(i));
        end
    end

    // Generator state plus registered draw outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= reset_seed(i);
            end
            rnd_out   <= '0;
            spike_out <= '0;
            out_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (seed_hit[i]) begin
                    state[i] <= seed_val;
                end else if (adv) begin
                    state[i]                   <= nxt[i];
                    rnd_out[i*OUT_W +: OUT_W]  <= nxt[i][OUT_W-1:0];
                    spike_out[i]               <= (nxt[i][OUT_W-1:0] < prob[i*OUT_W +: OUT_W]);
                end
            end
            if (adv) begin
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
